// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demux sequencer and the downstream demux.
// Channel width, channel count and FSM state encoding live here.
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0] sel_t;

   // 2'b11 is left unnamed on purpose; the FSM treats it as illegal and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      GAP   = 2'b10
   } state_e;

   function automatic sel_t nextChannel(input sel_t ch);
      return sel_t'((int'(ch) + 1) % NUM_CH);
   endfunction

endpackage

// File: rtl/demux_sequencer_if.sv
// Upstream handshake plus demux-facing outputs of the sequencer.
// The master side feeds symbols in; the slave side is the sequencer itself.
interface demux_sequencer_if
   import demux_pkg::*;
#(
   parameter int CNT_W = 8
);

   logic             in_valid;
   logic             in_ready;
   logic             in_data;
   sel_t             in_addr;
   logic             mode;
   logic             D;
   sel_t             S;
   logic             busy;
   logic [CNT_W-1:0] sym_count;

   modport master (
      output in_valid, in_data, in_addr, mode,
      input  in_ready, D, S, busy, sym_count
   );

   modport slave (
      input  in_valid, in_data, in_addr, mode,
      output in_ready, D, S, busy, sym_count
   );

endinterface

// File: rtl/demux_hold_timer.sv
// Loadable down-counter that tells the sequencer when a symbol's hold time is over.
// Loaded with HOLD_CYCLES-1 on accept, so done fires in the last DRIVE cycle.
module demux_hold_timer #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic done_o
);

   localparam logic [7:0] LOAD_VAL = 8'(HOLD_CYCLES - 1);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = LOAD_VAL;
      end else if (en_i && (count_q != 8'd0)) begin
         count_d = count_q - 8'd1;
      end
   end

   assign done_o = en_i && (count_q == 8'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/demux_sequencer.sv
// Drives one data bit and a channel select to the 1-to-4 demux for HOLD_CYCLES,
// then blanks D for a cycle so the select never changes while D is high.
module demux_sequencer
   import demux_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   demux_sequencer_if.slave bus
);

   state_e           state_q, state_d;
   logic             data_q, data_d;
   sel_t             addr_q, addr_d;
   sel_t             rrPtr_q, rrPtr_d;
   logic             dOut_q, dOut_d;
   sel_t             sel_q, sel_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] symCount_q, symCount_d;
   logic             accept;
   logic             holdDone;

   assign accept = (state_q == IDLE) && ready_q && bus.in_valid;

   demux_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_holdTimer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .en_i   (state_q == DRIVE),
      .done_o (holdDone)
   );

   // Mode is looked at only here, so flipping it mid-symbol cannot move S.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      addr_d     = addr_q;
      rrPtr_d    = rrPtr_q;
      symCount_d = symCount_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = DRIVE;
               data_d  = bus.in_data;
               if (bus.mode) begin
                  addr_d  = rrPtr_q;
                  rrPtr_d = nextChannel(rrPtr_q);
               end else begin
                  addr_d = bus.in_addr;
               end
            end
         end
         DRIVE: begin
            if (holdDone) begin
               state_d = GAP;
            end
         end
         GAP: begin
            state_d    = IDLE;
            symCount_d = symCount_q + CNT_W'(1);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are computed from the next state so they line up with it after the edge.
   always_comb begin
      dOut_d  = 1'b0;
      sel_d   = sel_q;
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE) && !accept;
      if (state_d == DRIVE) begin
         dOut_d = data_d;
         sel_d  = addr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         data_q     <= 1'b0;
         addr_q     <= '0;
         rrPtr_q    <= '0;
         dOut_q     <= 1'b0;
         sel_q      <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         symCount_q <= '0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
         rrPtr_q    <= rrPtr_d;
         dOut_q     <= dOut_d;
         sel_q      <= sel_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         symCount_q <= symCount_d;
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.D         = dOut_q;
   assign bus.S         = sel_q;
   assign bus.busy      = busy_q;
   assign bus.sym_count = symCount_q;

endmodule

// File: tb/tb_demux_sequencer.sv
// Scoreboard bench for demux_sequencer: one instance with HOLD_CYCLES=4/CNT_W=8,
// a second with HOLD_CYCLES=1/CNT_W=2 for the short-hold and counter-wrap case.
module tb_demux_sequencer;
   import demux_pkg::*;

   localparam int HOLD_A = 4;
   localparam int CNT_A  = 8;
   localparam int HOLD_B = 1;
   localparam int CNT_B  = 2;

   typedef struct packed {
      logic data;
      sel_t addr;
   } sym_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cycle = 0;
   int   checks = 0;
   int   passed = 0;
   sel_t rrModel = '0;
   sym_t expQ[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   demux_sequencer_if #(.CNT_W(CNT_A)) busA ();
   demux_sequencer_if #(.CNT_W(CNT_B)) busB ();

   demux_sequencer #(.HOLD_CYCLES(HOLD_A), .CNT_W(CNT_A)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busA.slave)
   );

   demux_sequencer #(.HOLD_CYCLES(HOLD_B), .CNT_W(CNT_B)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busB.slave)
   );

   task automatic resetDut();
      @(negedge clk);
      busA.in_valid = 1'b0;
      busB.in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rrModel = '0;
      expQ.delete();
   endtask

   // Offers a symbol on busA; on accept the expected symbol goes into the scoreboard.
   task automatic sendA(input logic d, input sel_t a, input logic m, output int ac);
      bit ok;
      ok = 1'b0;
      ac = -1;
      busA.in_data  = d;
      busA.in_addr  = a;
      busA.mode     = m;
      busA.in_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (busA.in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            ac = cycle;
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      busA.in_valid = 1'b0;
      checks++;
      if (!ok) begin
         $display("[TB] FAIL accept_timeout: in_ready=%b required 1", busA.in_ready);
      end else begin
         passed++;
         expQ.push_back('{data: d, addr: (m ? rrModel : a)});
         if (m) rrModel = rrModel + sel_t'(1);
      end
   endtask

   task automatic test_reset();
      busA.in_valid = 1'b0;
      busA.in_data  = 1'b0;
      busA.in_addr  = '0;
      busA.mode     = 1'b0;
      busB.in_valid = 1'b0;
      busB.in_data  = 1'b0;
      busB.in_addr  = '0;
      busB.mode     = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busA.in_ready, busA.D, busA.S, busA.busy, busA.sym_count} !== 13'd0)
         $display("[TB] FAIL reset_outputs: got %b required 0",
                  {busA.in_ready, busA.D, busA.S, busA.busy, busA.sym_count});
      else passed++;
      repeat (3) @(negedge clk);
      checks++;
      if (busA.in_ready !== 1'b0)
         $display("[TB] FAIL ready_in_reset: got %b required 0", busA.in_ready);
      else passed++;
      rst_n = 1'b1;
      #1;
      checks++;
      if (busA.in_ready !== 1'b0)
         $display("[TB] FAIL ready_before_edge: got %b required 0", busA.in_ready);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if ({busA.in_ready, busA.D, busA.S, busA.busy, busA.sym_count} !== {1'b1, 12'd0})
         $display("[TB] FAIL ready_after_release: got %b required %b",
                  {busA.in_ready, busA.D, busA.S, busA.busy, busA.sym_count}, {1'b1, 12'd0});
      else passed++;
      checks++;
      if (busB.in_ready !== 1'b1)
         $display("[TB] FAIL ready_after_release_b: got %b required 1", busB.in_ready);
      else passed++;
      rrModel = '0;
      expQ.delete();
   endtask

   task automatic test_explicit();
      sym_t e;
      int ac;
      logic [3:0] yExp, yObs;
      logic [4:0] obs, exp;
      resetDut();
      @(negedge clk);
      sendA(1'b1, 2'd2, 1'b0, ac);
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      yExp = e.data ? (4'b0001 << e.addr) : 4'b0000;
      for (int i = 0; i < HOLD_A; i++) begin
         @(negedge clk);
         obs = {busA.D, busA.S, busA.busy, busA.in_ready};
         exp = {e.data, e.addr, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) $display("[TB] FAIL explicit_drive[%0d]: got %b required %b", i, obs, exp);
         else passed++;
         yObs = busA.D ? (4'b0001 << busA.S) : 4'b0000;
         checks++;
         if (yObs !== yExp) $display("[TB] FAIL explicit_demux_y[%0d]: got %b required %b", i, yObs, yExp);
         else passed++;
      end
      @(negedge clk);
      obs = {busA.D, busA.S, busA.busy, busA.in_ready};
      exp = {1'b0, e.addr, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) $display("[TB] FAIL explicit_gap: got %b required %b", obs, exp);
      else passed++;
      @(negedge clk);
      obs = {busA.D, busA.S, busA.busy, busA.in_ready};
      exp = {1'b0, e.addr, 1'b0, 1'b1};
      checks++;
      if (obs !== exp || busA.sym_count !== 8'd1)
         $display("[TB] FAIL explicit_idle: got %b cnt %0d required %b cnt 1", obs, busA.sym_count, exp);
      else passed++;
   endtask

   task automatic test_rr_wrap();
      sym_t e;
      int ac, prevAc;
      logic [4:0] obs, exp;
      resetDut();
      @(negedge clk);
      prevAc = 0;
      for (int s = 0; s < 5; s++) begin
         sendA(1'b1, 2'd3, 1'b1, ac);
         if (expQ.size() == 0) return;
         e = expQ.pop_front();
         if (s > 0) begin
            checks++;
            if (ac - prevAc !== HOLD_A + 2)
               $display("[TB] FAIL rr_spacing[%0d]: got %0d required %0d", s, ac - prevAc, HOLD_A + 2);
            else passed++;
         end
         prevAc = ac;
         for (int i = 0; i < HOLD_A; i++) begin
            @(negedge clk);
            obs = {busA.D, busA.S, busA.busy, busA.in_ready};
            exp = {e.data, e.addr, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) $display("[TB] FAIL rr_drive[%0d][%0d]: got %b required %b", s, i, obs, exp);
            else passed++;
         end
         @(negedge clk);
         obs = {busA.D, busA.S, busA.busy, busA.in_ready};
         exp = {1'b0, e.addr, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) $display("[TB] FAIL rr_gap[%0d]: got %b required %b", s, obs, exp);
         else passed++;
         @(negedge clk);
      end
      checks++;
      if (busA.sym_count !== 8'd5)
         $display("[TB] FAIL rr_count: got %0d required 5", busA.sym_count);
      else passed++;
   endtask

   task automatic test_mode_switch();
      sym_t e;
      int ac;
      resetDut();
      @(negedge clk);
      sendA(1'b1, 2'd2, 1'b1, ac);
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      busA.mode    = 1'b0;
      busA.in_addr = 2'd3;
      for (int i = 0; i < HOLD_A; i++) begin
         @(negedge clk);
         checks++;
         if ({busA.D, busA.S} !== {e.data, e.addr})
            $display("[TB] FAIL modesw_hold[%0d]: got %b required %b", i, {busA.D, busA.S}, {e.data, e.addr});
         else passed++;
      end
      repeat (2) @(negedge clk);
      sendA(1'b1, 2'd3, 1'b0, ac);
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      @(negedge clk);
      checks++;
      if ({busA.D, busA.S} !== {e.data, e.addr})
         $display("[TB] FAIL modesw_explicit: got %b required %b", {busA.D, busA.S}, {e.data, e.addr});
      else passed++;
      repeat (HOLD_A + 1) @(negedge clk);
      sendA(1'b1, 2'd0, 1'b1, ac);
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      @(negedge clk);
      checks++;
      if ({busA.D, busA.S} !== {e.data, e.addr})
         $display("[TB] FAIL modesw_rr_held: got %b required %b", {busA.D, busA.S}, {e.data, e.addr});
      else passed++;
      repeat (HOLD_A + 1) @(negedge clk);
   endtask

   task automatic test_reset_mid_drive();
      sym_t e;
      int ac;
      logic [4:0] obs, exp;
      resetDut();
      @(negedge clk);
      sendA(1'b1, 2'd2, 1'b0, ac);
      if (expQ.size() == 0) return;
      void'(expQ.pop_front());
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busA.D, busA.S, busA.busy, busA.in_ready} !== 5'd0 || busA.sym_count !== 8'd0)
         $display("[TB] FAIL midreset_outputs: got %b cnt %0d required 0",
                  {busA.D, busA.S, busA.busy, busA.in_ready}, busA.sym_count);
      else passed++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rrModel = '0;
      @(posedge clk);
      #1;
      checks++;
      if (busA.in_ready !== 1'b1 || busA.sym_count !== 8'd0)
         $display("[TB] FAIL midreset_release: ready %b cnt %0d required ready 1 cnt 0",
                  busA.in_ready, busA.sym_count);
      else passed++;
      @(negedge clk);
      sendA(1'b1, 2'd1, 1'b0, ac);
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      @(negedge clk);
      obs = {busA.D, busA.S, busA.busy, busA.in_ready};
      exp = {e.data, e.addr, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) $display("[TB] FAIL midreset_newsym: got %b required %b", obs, exp);
      else passed++;
      repeat (HOLD_A + 1) @(negedge clk);
      checks++;
      if (busA.sym_count !== 8'd1 || busA.in_ready !== 1'b1)
         $display("[TB] FAIL midreset_count: cnt %0d ready %b required cnt 1 ready 1",
                  busA.sym_count, busA.in_ready);
      else passed++;
   endtask

   task automatic test_counter_wrap();
      sym_t e;
      int ac, prevAc;
      bit ok;
      logic [1:0] cntExp;
      logic [4:0] obs, exp;
      resetDut();
      @(negedge clk);
      cntExp = 2'd0;
      prevAc = 0;
      for (int s = 0; s < 5; s++) begin
         ok = 1'b0;
         busB.in_data  = 1'b1;
         busB.in_addr  = sel_t'(s);
         busB.mode     = 1'b0;
         busB.in_valid = 1'b1;
         for (int i = 0; i < 10 && !ok; i++) begin
            if (busB.in_ready === 1'b1) begin
               @(posedge clk);
               #1;
               ac = cycle;
               ok = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
         busB.in_valid = 1'b0;
         checks++;
         if (!ok) begin
            $display("[TB] FAIL wrap_accept_timeout[%0d]: in_ready=%b required 1", s, busB.in_ready);
            return;
         end
         passed++;
         expQ.push_back('{data: 1'b1, addr: sel_t'(s)});
         if (s > 0) begin
            checks++;
            if (ac - prevAc !== HOLD_B + 2)
               $display("[TB] FAIL wrap_spacing[%0d]: got %0d required %0d", s, ac - prevAc, HOLD_B + 2);
            else passed++;
         end
         prevAc = ac;
         e = expQ.pop_front();
         @(negedge clk);
         obs = {busB.D, busB.S, busB.busy, busB.in_ready};
         exp = {e.data, e.addr, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) $display("[TB] FAIL wrap_drive[%0d]: got %b required %b", s, obs, exp);
         else passed++;
         @(negedge clk);
         obs = {busB.D, busB.S, busB.busy, busB.in_ready};
         exp = {1'b0, e.addr, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) $display("[TB] FAIL wrap_gap[%0d]: got %b required %b", s, obs, exp);
         else passed++;
         @(negedge clk);
         cntExp = cntExp + 2'd1;
         checks++;
         if (busB.sym_count !== cntExp)
            $display("[TB] FAIL wrap_count[%0d]: got %0d required %0d", s, busB.sym_count, cntExp);
         else passed++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_explicit();
      test_rr_wrap();
      test_mode_switch();
      test_reset_mid_drive();
      test_counter_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
